// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: shares the register file's two write ports among NUM_REQ requesters
// with rotating priority, one registered output stage and a hold/drain quiesce FSM.
module reg_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [0:NUM_REQ-1]           req_valid_i,
    input  logic [0:NUM_REQ*ADDR_W-1]    req_addr_i,
    input  logic [0:NUM_REQ*DATA_W-1]    req_data_i,
    output logic [0:NUM_REQ-1]           req_ready_o,
    input  logic                         hold_i,
    output logic                         idle_o,
    output logic                         wr_en_1_o,
    output logic [ADDR_W-1:0]            wr_addr_1_o,
    output logic [DATA_W-1:0]            wr_data_1_o,
    output logic                         wr_en_2_o,
    output logic [ADDR_W-1:0]            wr_addr_2_o,
    output logic [DATA_W-1:0]            wr_data_2_o
);
    // state    | meaning
    // ST_RUN   | grants allowed while hold_i=0
    // ST_DRAIN | no grants; last registered writes leave the output stage
    // ST_HELD  | quiesced, no writes on either port, idle_o=1
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HELD} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic               grant_ok;
    logic               found_a, found_b;
    logic [PTR_W-1:0]   a_idx, b_idx, last_idx, scan_idx;
    logic [PTR_W:0]     scan_sum;
    logic [ADDR_W-1:0]  a_addr;
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    logic               idle_q;
    logic               wr_en_1_q, wr_en_2_q;
    logic [ADDR_W-1:0]  wr_addr_1_q, wr_addr_2_q;
    logic [DATA_W-1:0]  wr_data_1_q, wr_data_2_q;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr_i[i*ADDR_W +: ADDR_W];
            data_arr[i] = req_data_i[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (hold_i) state_d = ST_DRAIN;
            ST_DRAIN: state_d = hold_i ? ST_HELD : ST_RUN;
            ST_HELD:  if (!hold_i) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        grant_ok = (state_q == ST_RUN) && !hold_i;
    end

    // Scan from rr_q: first valid is A, next valid with a different address is B.
    always_comb begin
        found_a  = 1'b0;
        found_b  = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        a_addr   = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_q} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (req_valid_i[scan_idx]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    a_idx   = scan_idx;
                    a_addr  = addr_arr[scan_idx];
                end else if (!found_b && (addr_arr[scan_idx] != a_addr)) begin
                    found_b = 1'b1;
                    b_idx   = scan_idx;
                end
            end
        end
    end

    always_comb begin
        last_idx = found_b ? b_idx : a_idx;
        rr_d     = rr_q;
        if (grant_ok && found_a) begin
            rr_d = (last_idx == PTR_W'(NUM_REQ-1)) ? '0 : last_idx + 1'b1;
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (rst_n && grant_ok && found_a) begin
            req_ready_o[a_idx] = 1'b1;
            if (found_b) begin
                req_ready_o[b_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= '0;
            idle_q      <= 1'b0;
            wr_en_1_q   <= 1'b0;
            wr_en_2_q   <= 1'b0;
            wr_addr_1_q <= '0;
            wr_addr_2_q <= '0;
            wr_data_1_q <= '0;
            wr_data_2_q <= '0;
        end else begin
            rr_q      <= rr_d;
            idle_q    <= (state_d == ST_HELD);
            wr_en_1_q <= grant_ok && found_a;
            wr_en_2_q <= grant_ok && found_b;
            if (grant_ok && found_a) begin
                wr_addr_1_q <= addr_arr[a_idx];
                wr_data_1_q <= data_arr[a_idx];
            end
            if (grant_ok && found_b) begin
                wr_addr_2_q <= addr_arr[b_idx];
                wr_data_2_q <= data_arr[b_idx];
            end
        end
    end

    assign idle_o      = idle_q;
    assign wr_en_1_o   = wr_en_1_q;
    assign wr_en_2_o   = wr_en_2_q;
    assign wr_addr_1_o = wr_addr_1_q;
    assign wr_addr_2_o = wr_addr_2_q;
    assign wr_data_1_o = wr_data_1_q;
    assign wr_data_2_o = wr_data_2_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed test-plan steps then random traffic, all checked
// against a queue-based reference model of the grant rules and hold sequencing.
module tb_reg_wb_arbiter;
    localparam int N  = 4;
    localparam int AW = 7;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold = 1'b0;
    logic [0:N-1]    req_valid, req_ready;
    logic [0:N*AW-1] req_addr;
    logic [0:N*DW-1] req_data;
    logic            idle, wr_en_1, wr_en_2;
    logic [AW-1:0]   wr_addr_1, wr_addr_2;
    logic [DW-1:0]   wr_data_1, wr_data_2;

    logic            v [N];
    logic [AW-1:0]   a [N];
    logic [DW-1:0]   d [N];

    int              m_rr, m_mode;
    logic            e_en1, e_en2;
    logic [AW-1:0]   e_a1, e_a2;
    logic [DW-1:0]   e_d1, e_d2;
    int              last_ga, last_gb;
    logic [0:N-1]    last_ready;
    int              n_assert = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = v[i];
            req_addr[i*AW +: AW]   = a[i];
            req_data[i*DW +: DW]   = d[i];
        end
    end

    reg_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_ready_o(req_ready), .hold_i(hold), .idle_o(idle),
        .wr_en_1_o(wr_en_1), .wr_addr_1_o(wr_addr_1), .wr_data_1_o(wr_data_1),
        .wr_en_2_o(wr_en_2), .wr_addr_2_o(wr_addr_2), .wr_data_2_o(wr_data_2)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Valid requesters in priority order from rr; A is the head, B the first other address.
    task automatic model_arb(output int ga, output int gb);
        int q[$];
        ga = -1;
        gb = -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_rr + k) % N]) q.push_back((m_rr + k) % N);
        end
        if (q.size() > 0) begin
            ga = q[0];
            for (int j = 1; j < q.size(); j++) begin
                if (a[q[j]] != a[ga]) begin
                    gb = q[j];
                    break;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_mode = 0;
        e_en1 = 0; e_en2 = 0; e_a1 = '0; e_a2 = '0; e_d1 = '0; e_d2 = '0;
    endtask

    task automatic step();
        int ga, gb;
        logic [0:N-1] er;
        @(negedge clk);
        model_arb(ga, gb);
        if (!(m_mode == 0 && !hold)) begin
            ga = -1;
            gb = -1;
        end
        er = '0;
        if (ga >= 0) er[ga] = 1'b1;
        if (gb >= 0) er[gb] = 1'b1;
        last_ready = req_ready;
        last_ga = ga;
        last_gb = gb;
        chk("req_ready", req_ready, er);
        @(posedge clk);
        #1;
        e_en1 = (ga >= 0);
        e_en2 = (gb >= 0);
        if (ga >= 0) begin e_a1 = a[ga]; e_d1 = d[ga]; end
        if (gb >= 0) begin e_a2 = a[gb]; e_d2 = d[gb]; end
        if (ga >= 0) m_rr = (((gb >= 0) ? gb : ga) + 1) % N;
        case (m_mode)
            0: m_mode = hold ? 1 : 0;
            1: m_mode = hold ? 2 : 0;
            default: m_mode = hold ? 2 : 0;
        endcase
        chk("wr_en_1", wr_en_1, e_en1);
        chk("wr_addr_1", wr_addr_1, e_a1);
        chk("wr_data_1", wr_data_1, e_d1);
        chk("wr_en_2", wr_en_2, e_en2);
        chk("wr_addr_2", wr_addr_2, e_a2);
        chk("wr_data_2", wr_data_2, e_d2);
        chk("idle", idle, m_mode == 2);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_wr_en_1", wr_en_1, 0);
        chk("rst_wr_en_2", wr_en_2, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_idle", idle, 0);
        chk("rst_wr_addr_1", wr_addr_1, 0);
        chk("rst_wr_data_2", wr_data_2, 0);
        model_reset();
        hold = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic consume();
        for (int i = 0; i < N; i++) begin
            if (i == last_ga || i == last_gb || !v[i]) begin
                v[i] = ($urandom_range(0, 2) != 0);
                a[i] = AW'($urandom_range(0, 7));
                d[i] = rnd_data();
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; a[i] = '0; d[i] = '0;
        end
        model_reset();
        #1;
        chk("init_wr_en_1", wr_en_1, 0);
        chk("init_wr_en_2", wr_en_2, 0);
        chk("init_idle", idle, 0);
        chk("init_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single request from requester 1
        v[1] = 1'b1; a[1] = 7'd5; d[1] = {16{8'hA5}};
        step();
        chk("single_ready", last_ready, 4'b0100);
        chk("single_en1", wr_en_1, 1);
        chk("single_addr1", wr_addr_1, 5);
        chk("single_data1", wr_data_1, {16{8'hA5}});
        chk("single_en2", wr_en_2, 0);
        v[1] = 1'b0;
        step();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; a[i] = AW'(10 + i); d[i] = rnd_data();
        end
        step();
        chk("rr_after_single", last_ready, 4'b0011);

        // full load from rr=0 after a mid-traffic reset
        do_reset();
        step();
        chk("full_c1_ready", last_ready, 4'b1100);
        chk("full_c1_addr1", wr_addr_1, 10);
        chk("full_c1_addr2", wr_addr_2, 11);
        d[0] = rnd_data(); d[1] = rnd_data();
        step();
        chk("full_c2_ready", last_ready, 4'b0011);
        chk("full_c2_addr1", wr_addr_1, 12);
        d[2] = rnd_data(); d[3] = rnd_data();
        step();
        chk("full_c3_ready", last_ready, 4'b1100);

        // address conflict
        do_reset();
        a[0] = 7'd20; a[1] = 7'd20; a[2] = 7'd21; v[3] = 1'b0;
        d[0] = rnd_data(); d[1] = rnd_data(); d[2] = rnd_data();
        step();
        chk("conf_c1_ready", last_ready, 4'b1010);
        chk("conf_c1_addr1", wr_addr_1, 20);
        chk("conf_c1_addr2", wr_addr_2, 21);
        v[0] = 1'b0; v[2] = 1'b0;
        step();
        chk("conf_c2_ready", last_ready, 4'b0100);
        chk("conf_c2_addr1", wr_addr_1, 20);
        chk("conf_c2_data1", wr_data_1, d[1]);
        chk("conf_c2_en2", wr_en_2, 0);

        // hold sequence with all requesters valid (rr=2 here)
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; a[i] = AW'(30 + i); d[i] = rnd_data();
        end
        step();
        chk("hold_pre_ready", last_ready, 4'b0011);
        hold = 1'b1;
        step();
        chk("hold_n_ready", last_ready, 4'b0000);
        chk("hold_n1_en1", wr_en_1, 0);
        step();
        chk("hold_n2_idle", idle, 1);
        step();
        step();
        hold = 1'b0;
        step();
        chk("unhold_idle", idle, 0);
        step();
        chk("unhold_resume", last_ready, 4'b1100);

        // one-cycle hold pulse
        hold = 1'b1;
        step();
        hold = 1'b0;
        step();
        chk("pulse_idle", idle, 0);
        step();
        chk("pulse_resume", last_ready, 4'b0011);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            consume();
            hold = ($urandom_range(0, 9) == 0) ? ~hold : hold;
            if (c == 200) do_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

- Shares the register file's two write ports between NUM_REQ writeback requesters (even pipe, odd pipe, load/store, spare).
- Each cycle it grants up to two requests with rotating priority, never two to the same register.
- Grants are driven onto the write ports through one registered stage.
- A hold/drain state machine quiesces all writes, e.g. around register preload.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 7, register address width
- DATA_W, 128, register data width

Ports (vectors MSB-first `[0:N-1]`; requester i occupies slice i, e.g. req_addr `[i*ADDR_W : i*ADDR_W+ADDR_W-1]`):
- clk, input, 1, the single clock
- rst_n, input, 1, asynchronous active-low reset
- req_valid, input, NUM_REQ, requester i has a write pending
- req_addr, input, NUM_REQ*ADDR_W, destination register per requester
- req_data, input, NUM_REQ*DATA_W, write data per requester
- req_ready, output, NUM_REQ, combinational; request i accepted this cycle
- hold, input, 1, request to quiesce writes
- idle, output, 1, registered; arbiter is in HELD with no write in flight
- wr_en_1, output, 1, write port 1 enable (registered)
- wr_addr_1, output, ADDR_W, write port 1 address
- wr_data_1, output, DATA_W, write port 1 data
- wr_en_2, output, 1, write port 2 enable
- wr_addr_2, output, ADDR_W, write port 2 address
- wr_data_2, output, DATA_W, write port 2 data

## Operation
- State machine states and transitions:
  - RUN to DRAIN when hold=1.
  - DRAIN to HELD if hold=1, otherwise back to RUN.
  - HELD to RUN when hold=0.
- Grants are made only in RUN with hold=0. In DRAIN and HELD, req_ready=0.
- Round-robin pointer rr_ptr (0..NUM_REQ-1). Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ:
  - The first valid requester is grant A and goes to port 1.
  - The next valid requester whose req_addr differs from A's is grant B and goes to port 2.
  - A valid requester with the same address as A is skipped this cycle, and scanning continues past it.
- Port 1 always carries the older-priority grant. Two ports never carry the same address in one cycle.
- rr_ptr update: set to (index of last grant this cycle + 1) mod NUM_REQ. If nothing was granted, rr_ptr is unchanged.
- Handshake: a request transfers when req_valid[i] and req_ready[i] are both 1.
  - Requesters hold valid, addr and data stable until they see ready.
  - req_valid must not depend on req_ready.
- Output register: each granted (addr, data) is captured at the clock edge and appears on wr_* in the next cycle, with wr_en asserted for exactly 1 cycle.
  - A port with no grant drives wr_en=0. Its addr and data hold their previous values.
- idle=1 only in HELD. In HELD, wr_en_1 and wr_en_2 are guaranteed 0, so preload can safely proceed.

## Timing
- Reset (rst_n=0, asynchronous): state=RUN, rr_ptr=0, wr_en_1=wr_en_2=0, wr_addr_*=0, wr_data_*=0, idle=0.
  - Any write captured but not yet driven is discarded.
  - req_ready=0 while rst_n=0.
- Latency: a request accepted in cycle N appears on wr_* in cycle N+1.
- hold raised in cycle N: no grant in N; state=DRAIN in N+1. That cycle's wr_* shows only grants from N-1 or none.
  - HELD is reached in N+2, and idle=1 from N+2.
- hold dropped while HELD in cycle M: RUN in M+1; grants are possible from M+1.
- With all NUM_REQ requesters continuously valid with distinct addresses, every requester is granted at least once every ceil(NUM_REQ/2) cycles (no starvation).
- A same-address pair among those valid requesters is serialised over two cycles:
  - The requester nearer to rr_ptr goes first.
  - rr_ptr then moves past it, so the other one goes next.

## Test plan
- Reset: drive rst_n=0 mid-traffic. Required: wr_en_1=wr_en_2=0 and req_ready=0 immediately; idle=0; after release, the first grant goes to requester 0.
- Single request: req_valid=0100, req_addr[1]=7'd5, data=128'hA5... Required: req_ready=0100 that cycle; next cycle wr_en_1=1, wr_addr_1=5, wr_en_2=0; rr_ptr=2.
- Full load, distinct addresses 10,11,12,13, held valid. Required grants by cycle:
  - cycle 1: {0→port 1, 1→port 2}
  - cycle 2: {2, 3}
  - cycle 3: {0, 1}
  - wr_* matches each pair one cycle later.
- Address conflict: requesters 0 and 1 both target register 20, requester 2 targets 21, rr_ptr=0. Required:
  - cycle 1: ports carry (20 from 0, 21 from 2) and requester 1 is not ready.
  - cycle 2: requester 1 is granted, so wr_addr_1=20 with its data.
- Hold sequence: assert hold with all requesters valid. Required:
  - req_ready=0 from that cycle.
  - One cycle later, wr_en reflects only the prior cycle's grants.
  - idle=1 two cycles after hold.
  - Drop hold: idle=0 next cycle and grants resume in rotation from the saved rr_ptr.
- hold pulse of 1 cycle: RUN→DRAIN→RUN. Required: idle stays 0; grants resume 2 cycles after the pulse began.
